// File: rtl/id_control_seq_if.sv
// rtl/id_control_seq_if.sv - IF/ID-side instruction bus and ID/EX-side control bundle
interface id_control_seq_if #(
    parameter int CMD_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [1:0]       mode;
    logic [3:0]       opcode;
    logic             s_in;
    logic [3:0]       status;
    logic             hazard;
    logic             flush;
    logic             out_valid;
    logic [CMD_W-1:0] exe_cmd;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s_out;
    logic             mul_busy;

    // Pipeline side that presents instructions and consumes controls
    modport master (
        output in_valid, cond, mode, opcode, s_in, status, hazard, flush,
        input  in_ready, out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, b, s_out, mul_busy
    );

    // Control unit side
    modport slave (
        input  in_valid, cond, mode, opcode, s_in, status, hazard, flush,
        output in_ready, out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, b, s_out, mul_busy
    );
endinterface

// File: rtl/id_control_seq.sv
// rtl/id_control_seq.sv - ID-stage control decode with cond eval, stall, flush and MUL sequencer
module id_control_seq #(
    parameter int CMD_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    id_control_seq_if.slave    bus
);
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CMD_MUL  = 4'b1010;
    localparam int         MUL_LOAD = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mul_s_q, mul_s_d;
    logic              out_valid_q, out_valid_d;
    logic [CMD_W-1:0]  exe_cmd_q, exe_cmd_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              b_q, b_d;
    logic              s_out_q, s_out_d;
    logic              mul_busy_q, mul_busy_d;

    logic [3:0] dec_cmd;
    logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s, dec_is_mul;
    logic       cond_ok;
    logic       in_ready;
    logic       accept;

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = bus.status;

    // Held low while reset is asserted so upstream never sees a ready during reset
    assign in_ready = rst_n && !bus.hazard && (state_q == ST_RUN);
    // Flush suppresses acceptance even though in_ready may be high
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    // Instruction field decode into raw controls
    always_comb begin
        dec_cmd    = 4'b0000;
        dec_wb     = 1'b0;
        dec_mr     = 1'b0;
        dec_mw     = 1'b0;
        dec_b      = 1'b0;
        dec_s      = 1'b0;
        dec_is_mul = 1'b0;
        case (bus.mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = bus.s_in;
                case (bus.opcode)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin
                        dec_cmd = 4'b0100;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    4'b1000: begin
                        dec_cmd = 4'b0110;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    default: begin
                        dec_wb = 1'b0;
                        dec_s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                if (bus.opcode == 4'b0100) begin
                    dec_cmd = 4'b0010;
                    dec_wb  = bus.s_in;
                    dec_mr  = bus.s_in;
                    dec_mw  = !bus.s_in;
                end
            end
            2'b10: begin
                dec_b = !bus.opcode[3];
            end
            default: begin
                if (bus.opcode == 4'b0000) begin
                    dec_cmd    = CMD_MUL;
                    dec_wb     = 1'b1;
                    dec_s      = bus.s_in;
                    dec_is_mul = 1'b1;
                end
            end
        endcase
    end

    // ARM condition evaluation against the flags presented with the instruction
    always_comb begin
        cond_ok = 1'b0;
        case (bus.cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Next-state and next-output logic; default is a bubble
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_s_d     = mul_s_q;
        out_valid_d = 1'b0;
        exe_cmd_d   = '0;
        wb_en_d     = 1'b0;
        mem_r_en_d  = 1'b0;
        mem_w_en_d  = 1'b0;
        b_d         = 1'b0;
        s_out_d     = 1'b0;
        mul_busy_d  = 1'b0;

        if (bus.flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && cond_ok) begin
                        if (dec_is_mul && (MUL_CYCLES > 1)) begin
                            state_d    = ST_MUL_WAIT;
                            cnt_d      = CNT_W'(MUL_LOAD);
                            mul_s_d    = bus.s_in;
                            mul_busy_d = 1'b1;
                        end else begin
                            out_valid_d = 1'b1;
                            exe_cmd_d   = CMD_W'(dec_cmd);
                            wb_en_d     = dec_wb;
                            mem_r_en_d  = dec_mr;
                            mem_w_en_d  = dec_mw;
                            b_d         = dec_b;
                            s_out_d     = dec_s;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d      = cnt_q - CNT_W'(1);
                        mul_busy_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        out_valid_d = 1'b1;
                        exe_cmd_d   = CMD_W'(CMD_MUL);
                        wb_en_d     = 1'b1;
                        s_out_d     = mul_s_q;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ID/EX boundary registers and sequencer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            mul_s_q     <= 1'b0;
            out_valid_q <= 1'b0;
            exe_cmd_q   <= '0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            b_q         <= 1'b0;
            s_out_q     <= 1'b0;
            mul_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_s_q     <= mul_s_d;
            out_valid_q <= out_valid_d;
            exe_cmd_q   <= exe_cmd_d;
            wb_en_q     <= wb_en_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            b_q         <= b_d;
            s_out_q     <= s_out_d;
            mul_busy_q  <= mul_busy_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.exe_cmd   = exe_cmd_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.mem_r_en  = mem_r_en_q;
    assign bus.mem_w_en  = mem_w_en_q;
    assign bus.b         = b_q;
    assign bus.s_out     = s_out_q;
    assign bus.mul_busy  = mul_busy_q;
endmodule

// File: tb/tb_id_control_seq.sv
// tb/tb_id_control_seq.sv - randomized and directed check of id_control_seq against a reference model
module tb_id_control_seq;
    localparam int CMD_W      = 4;
    localparam int MUL_CYCLES = 3;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic       ov;
        logic [3:0] cmd;
        logic       wb;
        logic       mr;
        logic       mw;
        logic       b;
        logic       s;
        logic       busy;
    } ctrl_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_control_seq_if #(.CMD_W(CMD_W)) bus ();

    id_control_seq #(
        .CMD_W(CMD_W),
        .MUL_CYCLES(MUL_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [10:0] dut_out;
    assign dut_out = {bus.out_valid, bus.exe_cmd, bus.wb_en, bus.mem_r_en,
                      bus.mem_w_en, bus.b, bus.s_out, bus.mul_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: expected registered outputs, edges left before a pending MUL emits
    ctrl_t m_out;
    int    m_left;
    logic  m_mul_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Conditions come in true/complement pairs; odd codes invert the even one
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] st);
        logic n, z, cf, v, base;
        {n, z, cf, v} = st;
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c >> 1)
            0: base = z;
            1: base = cf;
            2: base = n;
            3: base = v;
            4: base = cf & ~z;
            5: base = (n == v);
            default: base = ~z & (n == v);
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic ctrl_t ref_decode(input logic [1:0] m, input logic [3:0] op, input logic s);
        ctrl_t r;
        r = '0;
        r.ov = 1'b1;
        if (m == 2'b00) begin
            case (op)
                4'hD: begin r.cmd = 4'h1; r.wb = 1; r.s = s; end
                4'hF: begin r.cmd = 4'h9; r.wb = 1; r.s = s; end
                4'h4: begin r.cmd = 4'h2; r.wb = 1; r.s = s; end
                4'h5: begin r.cmd = 4'h3; r.wb = 1; r.s = s; end
                4'h2: begin r.cmd = 4'h4; r.wb = 1; r.s = s; end
                4'h6: begin r.cmd = 4'h5; r.wb = 1; r.s = s; end
                4'h0: begin r.cmd = 4'h6; r.wb = 1; r.s = s; end
                4'hC: begin r.cmd = 4'h7; r.wb = 1; r.s = s; end
                4'h1: begin r.cmd = 4'h8; r.wb = 1; r.s = s; end
                4'hA: begin r.cmd = 4'h4; r.s = 1; end
                4'h8: begin r.cmd = 4'h6; r.s = 1; end
                default: ;
            endcase
        end else if (m == 2'b01) begin
            if (op == 4'h4 && s)  begin r.cmd = 4'h2; r.wb = 1; r.mr = 1; end
            if (op == 4'h4 && !s) begin r.cmd = 4'h2; r.mw = 1; end
        end else if (m == 2'b10) begin
            r.b = (op < 4'd8);
        end else if (op == 4'h0) begin
            r.cmd = 4'hA; r.wb = 1; r.s = s;
        end
        return r;
    endfunction

    task automatic model_edge(input logic v, input logic [3:0] c, input logic [1:0] m,
                              input logic [3:0] op, input logic s, input logic [3:0] st,
                              input logic hz, input logic fl);
        ctrl_t nxt;
        nxt = '0;
        if (fl) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                nxt.ov = 1; nxt.cmd = 4'hA; nxt.wb = 1; nxt.s = m_mul_s;
            end else begin
                nxt.busy = 1;
            end
        end else if (v && !hz && ref_cond(c, st)) begin
            if (m == 2'b11 && op == 4'h0 && MUL_CYCLES > 1) begin
                m_left   = MUL_CYCLES - 1;
                m_mul_s  = s;
                nxt.busy = 1;
            end else begin
                nxt = ref_decode(m, op, s);
            end
        end
        m_out = nxt;
    endtask

    // One clock: drive at the falling edge, check ready, then check registered outputs after the edge
    task automatic step(input logic v, input logic [3:0] c, input logic [1:0] m,
                        input logic [3:0] op, input logic s, input logic [3:0] st,
                        input logic hz, input logic fl);
        bus.in_valid = v;
        bus.cond     = c;
        bus.mode     = m;
        bus.opcode   = op;
        bus.s_in     = s;
        bus.status   = st;
        bus.hazard   = hz;
        bus.flush    = fl;
        #1;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!hz && m_left == 0)});
        model_edge(v, c, m, op, s, st, hz, fl);
        @(posedge clk);
        #1;
        check("ctrl", {21'd0, dut_out}, {21'd0, m_out});
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] rm;
        logic [3:0] rop, rc;
        n_checks     = 0;
        n_fail       = 0;
        m_out        = '0;
        m_left       = 0;
        m_mul_s      = 0;
        rst_n        = 1'b0;
        bus.in_valid = 0;
        bus.cond     = 0;
        bus.mode     = 0;
        bus.opcode   = 0;
        bus.s_in     = 0;
        bus.status   = 0;
        bus.hazard   = 0;
        bus.flush    = 0;
        #1;
        check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out", {21'd0, dut_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // ADD with S, always
        step(1, 4'hE, 2'b00, 4'h4, 1, 4'h0, 0, 0);
        check("add_cmd", {28'd0, bus.exe_cmd}, 32'h2);
        check("add_wb_s", {30'd0, bus.wb_en, bus.s_out}, 32'h3);
        // CMP then LDR back-to-back
        step(1, 4'hE, 2'b00, 4'hA, 0, 4'h0, 0, 0);
        check("cmp_cmd", {28'd0, bus.exe_cmd}, 32'h4);
        step(1, 4'hE, 2'b01, 4'h4, 1, 4'h0, 0, 0);
        check("ldr_mr", {31'd0, bus.mem_r_en}, 32'h1);
        // BEQ taken and not taken
        step(1, 4'h0, 2'b10, 4'h3, 0, 4'b0100, 0, 0);
        check("beq_b", {31'd0, bus.b}, 32'h1);
        step(1, 4'h0, 2'b10, 4'h3, 0, 4'b0000, 0, 0);
        check("bne_ov", {31'd0, bus.out_valid}, 32'h0);
        // MUL with a second MUL held off until return to RUN
        step(1, 4'hE, 2'b11, 4'h0, 1, 4'h0, 0, 0);
        step(1, 4'hE, 2'b11, 4'h0, 0, 4'h0, 0, 0);
        step(1, 4'hE, 2'b11, 4'h0, 0, 4'h0, 0, 0);
        check("mul_emit", {28'd0, bus.exe_cmd}, 32'hA);
        step(1, 4'hE, 2'b11, 4'h0, 0, 4'h0, 0, 0);
        check("mul2_busy", {31'd0, bus.mul_busy}, 32'h1);
        step(0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 0, 0);
        step(0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 0, 0);
        // Hazard stall for two cycles
        step(1, 4'hE, 2'b00, 4'hD, 0, 4'h0, 1, 0);
        step(1, 4'hE, 2'b00, 4'hD, 0, 4'h0, 1, 0);
        step(1, 4'hE, 2'b00, 4'hD, 0, 4'h0, 0, 0);
        // Flush during MUL wait, flush beats hazard
        step(1, 4'hE, 2'b11, 4'h0, 1, 4'h0, 0, 0);
        step(1, 4'hE, 2'b00, 4'h4, 0, 4'h0, 1, 1);
        step(1, 4'hE, 2'b00, 4'h4, 0, 4'h0, 0, 1);
        step(0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 0, 0);
        // Async reset pulse mid-MUL
        step(1, 4'hE, 2'b11, 4'h0, 1, 4'h0, 0, 0);
        bus.in_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_rst_out", {21'd0, dut_out}, 32'd0);
        check("amid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        m_out  = '0;
        m_left = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rm  = 2'($urandom_range(0, 3));
            rop = 4'($urandom_range(0, 15));
            if (rm == 2'b01 && $urandom_range(0, 1) == 0) rop = 4'h4;
            if (rm == 2'b11 && $urandom_range(0, 1) == 0) rop = 4'h0;
            rc  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 8, rc, rm, rop, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 2,
                 $urandom_range(0, 29) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_control_seq.md
Name: id_control_seq

Overview:
- Next-generation ID-stage control unit for the ARM pipeline.
- Decodes cond/mode/opcode/S into execute, memory and write-back controls, and registers them into the ID/EX boundary.
- Adds condition-code evaluation, hazard stall, branch flush, a valid/ready input handshake, and a multi-cycle multiply sequencer (mode 11).
- Sits between the IF/ID register and the ID/EX register. Replaces the purely combinational decoder.

Parameters:
CMD_W, 4, width of exe_cmd (min 4); codes below occupy bits [3:0], upper bits always 0
MUL_CYCLES, 3, total cycles a MUL occupies the unit (min 1)
CNT_W, 2, width of multiply counter; must hold MUL_CYCLES-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID presents an instruction
in_ready  out  1  unit can accept this cycle
cond  in  4  ARM condition field
mode  in  2  instruction mode field
opcode  in  4  opcode field
s_in  in  1  S bit (L bit for mode 01)
status  in  4  NZCV flags {N,Z,C,V}
hazard  in  1  data hazard stall request
flush  in  1  taken-branch flush
out_valid  out  1  registered controls hold a live instruction
exe_cmd  out  CMD_W  ALU command
wb_en  out  1  register write-back
mem_r_en  out  1  memory read
mem_w_en  out  1  memory write
b  out  1  branch taken
s_out  out  1  update flags
mul_busy  out  1  multiply in progress

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state RUN, counter 0. in_ready is 0 during reset; after reset it is 1 unless stalled.
- in_ready = !hazard && state==RUN. Accept when in_valid && in_ready. Latency is 1 cycle: controls appear on the registered outputs at the next edge.
- Mode 00 decode (opcode -> exe_cmd, wb_en=1): MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000. s_out=s_in for these.
- CMP 1010 -> 0100, wb_en=0, s_out=1. TST 1000 -> 0110, wb_en=0, s_out=1.
- Any other mode-00 opcode: all controls 0.
- Mode 01: opcode 0100 with s_in=1 is LDR: exe_cmd 0010, wb_en=1, mem_r_en=1, s_out=0. Opcode 0100 with s_in=0 is STR: exe_cmd 0010, mem_w_en=1, s_out=0. Other opcodes: all 0.
- Mode 10: b=1 iff opcode[3]==0; other controls 0.
- Mode 11: opcode 0000 is MUL: exe_cmd 1010, wb_en=1, s_out=s_in, multi-cycle. Any other mode-11 opcode: all 0, single-cycle.
- Condition evaluation uses status sampled at acceptance:
  - EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V.
  - HI = C&!Z; LS = !C|Z.
  - GE = N==V; LT = N!=V; GT = !Z&(N==V); LE = Z|(N!=V).
  - AL (1110) always true; 1111 always false.
  - A false condition is accepted but produces out_valid=0 with all controls 0. A MUL with a false condition does not enter MUL_WAIT.
- Accepted, condition true, non-MUL: out_valid=1 with decoded controls.
- Cycles with no acceptance (idle or hazard): out_valid=0, all controls 0 (bubble).
- FSM states: RUN, MUL_WAIT.
  - MUL accepted in RUN with MUL_CYCLES==1: handled like a single-cycle op.
  - MUL accepted in RUN with MUL_CYCLES>1: counter <= MUL_CYCLES-2, go to MUL_WAIT, mul_busy=1, out_valid=0.
  - In MUL_WAIT: if counter!=0, decrement. If counter==0, emit MUL controls with out_valid=1, mul_busy=0, return to RUN.
  - A MUL of MUL_CYCLES=3 therefore holds in_ready=0 for 2 cycles and emits on the 3rd edge after acceptance.
- hazard in MUL_WAIT has no effect; the counter keeps running.
- flush (synchronous, highest priority): at the edge, all outputs go to 0, state goes to RUN, counter to 0, mul_busy to 0. No instruction is accepted that cycle, even if in_ready=1.
- flush together with hazard: flush wins. flush in MUL_WAIT aborts the multiply with no emission.
- Reset asserted mid-MUL: immediate return to reset values.

Test Plan:
- Reset then ADD (mode 00, opcode 0100, s_in=1, cond 1110), in_valid=1 -> next edge: out_valid=1, exe_cmd=0010, wb_en=1, s_out=1, others 0.
- CMP cond AL, then LDR (mode 01, opcode 0100, s_in=1) back-to-back -> exe_cmd 0100/wb_en=0/s_out=1, then 0010/wb_en=1/mem_r_en=1/s_out=0 on consecutive cycles.
- BEQ (mode 10, opcode 0xxx, cond 0000) with status Z=1 -> b=1, out_valid=1. Repeat with Z=0 -> out_valid=0, b=0, in_ready stays 1.
- MUL with MUL_CYCLES=3 -> in_ready=0 and mul_busy=1 for 2 cycles, then exe_cmd=1010, wb_en=1, out_valid=1 on 3rd edge. A second MUL presented meanwhile is accepted only after return to RUN.
- hazard=1 for 2 cycles with in_valid=1 -> in_ready=0, two bubble cycles (out_valid=0); the instruction is accepted on the first cycle hazard=0.
- flush=1 during MUL_WAIT -> next edge: mul_busy=0, out_valid=0, in_ready=1, no MUL emission. Async rst_n pulse mid-MUL -> outputs 0 immediately.
